// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared MEM->WB types and constants.
// Holds the default pipeline widths, the zero-register index and the
// default-width MEM->WB payload struct.
package mips_pipe_pkg;
    localparam int MEM_WB_DATA_W = 32;
    localparam int MEM_WB_REG_AW = 5;
    localparam int REG_ZERO      = 0;

    typedef struct packed {
        logic                     wb_en;
        logic                     mem_r_en;
        logic [MEM_WB_DATA_W-1:0] alu_result;
        logic [MEM_WB_DATA_W-1:0] mem_read_value;
        logic [MEM_WB_REG_AW-1:0] dest;
    } mem_wb_payload_t;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic valid/ready 2-entry (main + skid) buffer over an opaque payload.
// Ports: clk, rst (sync, active-high), flush (drops both entries),
//        in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data downstream.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic         accept;

    // Ready depends only on registered state, so out_ready never reaches in_ready.
    assign in_ready  = !skid_valid_q & !rst;
    assign accept    = in_valid & in_ready;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = in_data;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_data;
            skid_valid_d = 1'b1;
        end
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end
endmodule

// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg: MEM->WB pipeline register with skid buffer, rf write enable and wb data select.
// Ports: clk, rst (sync, active-high), flush; in_valid/in_ready + wb_en_in, mem_r_en_in,
//        alu_result_in, mem_read_value_in, dest_in upstream; out_valid/out_ready + registered
//        wb_en, mem_r_en, alu_result, mem_read_value, dest downstream; rf_we, wb_data.
// Optional MEM_WB_PERF_CNT_EN: adds saturating stall_cnt / bubble_cnt outputs (CNT_W wide).
module mem_wb_pipe_reg
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = MEM_WB_DATA_W,
    parameter int REG_AW = MEM_WB_REG_AW
`ifdef MEM_WB_PERF_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] mem_read_value_in,
    input  logic [REG_AW-1:0] dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] mem_read_value,
    output logic [REG_AW-1:0] dest,
    output logic              rf_we,
    output logic [DATA_W-1:0] wb_data
`ifdef MEM_WB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);
    localparam int PW = 2 + 2 * DATA_W + REG_AW;

    logic [PW-1:0] in_pl, out_pl;

    assign in_pl = {wb_en_in, mem_r_en_in, alu_result_in, mem_read_value_in, dest_in};
    assign {wb_en, mem_r_en, alu_result, mem_read_value, dest} = out_pl;

    pipe_skid_buf #(.W(PW)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pl)
    );

    // Register 0 is hardwired zero, so writes to it are suppressed.
    assign rf_we   = out_valid & out_ready & wb_en & (dest != REG_AW'(REG_ZERO));
    assign wb_data = mem_r_en ? mem_read_value : alu_result;

`ifdef MEM_WB_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = (out_valid & !out_ready & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        bubble_cnt_d = (!out_valid & out_ready & ~&bubble_cnt_q) ? bubble_cnt_q + 1'b1 : bubble_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// tb_mem_wb_pipe_reg: scoreboard bench for mem_wb_pipe_reg.
module tb_mem_wb_pipe_reg;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, wb_en_in, mem_r_en_in;
    logic          out_valid, out_ready, wb_en, mem_r_en, rf_we;
    logic [DW-1:0] alu_result_in, mem_read_value_in, alu_result, mem_read_value, wb_data;
    logic [AW-1:0] dest_in, dest;
`ifdef MEM_WB_PERF_CNT_EN
    logic [15:0]   stall_cnt, bubble_cnt;
`endif

    typedef struct packed {
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
        logic          we;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    bit   acc;

    always #5 clk = ~clk;

    mem_wb_pipe_reg dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .wb_en_in          (wb_en_in),
        .mem_r_en_in       (mem_r_en_in),
        .alu_result_in     (alu_result_in),
        .mem_read_value_in (mem_read_value_in),
        .dest_in           (dest_in),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .wb_en             (wb_en),
        .mem_r_en          (mem_r_en),
        .alu_result        (alu_result),
        .mem_read_value    (mem_read_value),
        .dest              (dest),
        .rf_we             (rf_we),
        .wb_data           (wb_data)
`ifdef MEM_WB_PERF_CNT_EN
        ,
        .stall_cnt         (stall_cnt),
        .bubble_cnt        (bubble_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input logic we, input logic mr, input logic [DW-1:0] alu,
                         input logic [DW-1:0] mem, input logic [AW-1:0] d);
        in_valid          = 1'b1;
        wb_en_in          = we;
        mem_r_en_in       = mr;
        alu_result_in     = alu;
        mem_read_value_in = mem;
        dest_in           = d;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // One clock: compare any consume and record any accept at the negedge,
    // then advance past the rising edge.
    task automatic step(output bit accepted);
        exp_t e;
        @(negedge clk);
        accepted = 1'b0;
        if (out_valid && out_ready) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_dest", 64'(dest), 64'(e.dest));
                check("out_wb_data", 64'(wb_data), 64'(e.data));
                check("out_rf_we", 64'(rf_we), 64'(e.we));
            end
        end
        if (in_valid && in_ready && !flush && !rst) begin
            e.dest = dest_in;
            e.data = mem_r_en_in ? mem_read_value_in : alu_result_in;
            e.we   = wb_en_in && (dest_in != '0);
            sb.push_back(e);
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) step(acc);
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0);
        idle();
        step(acc);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_alu", 64'(alu_result), 64'd0);
        check("rst_dest", 64'(dest), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Stream with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, DW'(32'h10 + i), '0, AW'(i + 1));
            step(acc);
            if (i == 0) check("stream_latency", 64'(out_valid), 64'd1);
        end
        idle();
        drain();

        // Load vs ALU select.
        drive(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 5'd7);
        step(acc);
        check("load_wb_data", 64'(wb_data), 64'hDEADBEEF);
        drive(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 5'd8);
        step(acc);
        check("alu_wb_data", 64'(wb_data), 64'h100);
        idle();
        drain();

        // Back-pressure: A in main, B in skid, C stalled upstream.
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 32'hA, '0, 5'd9);
        step(acc);
        drive(1'b1, 1'b0, 32'hB, '0, 5'd10);
        step(acc);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        drive(1'b1, 1'b0, 32'hC, '0, 5'd11);
        step(acc);
        step(acc);
        check("bp_hold_dest", 64'(dest), 64'd9);
        check("bp_c_stalled", 64'(sb.size()), 64'd2);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) step(acc);
        check("bp_c_accepted", 64'(acc), 64'd1);
        idle();
        drain();

        // Flush with main and skid full and a third entry offered.
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 32'hD, '0, 5'd12);
        step(acc);
        drive(1'b1, 1'b0, 32'hE, '0, 5'd13);
        step(acc);
        drive(1'b1, 1'b0, 32'hF, '0, 5'd14);
        flush = 1'b1;
        step(acc);
        flush = 1'b0;
        idle();
        sb.delete();
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step(acc);
        check("flush_no_rf_we", 64'(rf_we), 64'd0);

        // Zero destination register.
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h55, '0, 5'd0);
        step(acc);
        idle();
        out_ready = 1'b1;
        #1;
        check("zero_out_valid", 64'(out_valid), 64'd1);
        check("zero_rf_we", 64'(rf_we), 64'd0);
        drain();

        // Reset mid-stall.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h77, 32'h88, 5'd3);
        step(acc);
        drive(1'b1, 1'b1, 32'h99, 32'hAA, 5'd4);
        step(acc);
        idle();
        rst = 1'b1;
        step(acc);
        sb.delete();
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_in_ready", 64'(in_ready), 64'd0);
        check("mrst_alu", 64'(alu_result), 64'd0);
        check("mrst_mem", 64'(mem_read_value), 64'd0);
        check("mrst_dest", 64'(dest), 64'd0);
        check("mrst_flags", 64'({wb_en, mem_r_en}), 64'd0);
`ifdef MEM_WB_PERF_CNT_EN
        check("mrst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        rst = 1'b0;
        #1;
        check("mrst_in_ready_after", 64'(in_ready), 64'd1);

`ifdef MEM_WB_PERF_CNT_EN
        drive(1'b1, 1'b0, 32'h1, '0, 5'd2);
        step(acc);
        idle();
        for (int i = 0; i < 3; i++) step(acc);
        check("stall_cnt_3", 64'(stall_cnt), 64'd3);
`endif
        out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
